// File: rtl/systolic_pkg.sv
// Shared systolic-array definitions: array geometry and the
// result drain buffer state encoding.
package systolic_pkg;

  localparam int N           = 8;
  localparam int ACC_W       = 32;
  localparam int DRAIN_BEATS = 2 * N - 1;

  typedef enum logic [1:0] {
    EMPTY,
    CAPTURE,
    READOUT
  } drain_state_t;

endpackage

// File: rtl/result_store.sv
// N x N accumulator storage: deskewing writes from the drain beat
// index and a combinational row read mux.
module result_store #(
  parameter int N     = 8,
  parameter int ACC_W = 32,
  parameter int KW    = 4,
  parameter int RW    = 3
) (
  input  logic               clk,
  input  logic               we,
  input  logic [KW-1:0]      k,
  input  logic [N*ACC_W-1:0] drain_data,
  input  logic [RW-1:0]      row,
  output logic [N*ACC_W-1:0] row_data
);

  logic [ACC_W-1:0] mem [N][N];

  // Beat k carries C[i][j] on column j exactly when i + j == k.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (we && (k == KW'(i + j))) begin
          mem[i][j] <= drain_data[j*ACC_W +: ACC_W];
        end
      end
    end
  end

  always_comb begin
    row_data = '0;
    for (int j = 0; j < N; j++) begin
      row_data[j*ACC_W +: ACC_W] = mem[row][j];
    end
  end

endmodule

// File: rtl/result_drain_buffer.sv
// Captures skewed drain wavefronts into an N x N matrix and serves
// it one row per valid/ready beat.
module result_drain_buffer #(
  parameter int N     = systolic_pkg::N,
  parameter int ACC_W = systolic_pkg::ACC_W,
  localparam int RW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               output_write,
  input  logic [N*ACC_W-1:0] drain_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [N*ACC_W-1:0] rd_data,
  output logic [RW-1:0]      rd_row,
  output logic               rd_last,
  output logic               buf_empty,
  output logic               overflow_err
);

  import systolic_pkg::*;

  localparam int BEATS = 2 * N - 1;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(N - 1);

  drain_state_t     state, state_n;
  logic [KW-1:0]    k, k_n;
  logic [RW-1:0]    row, row_n;
  logic             ovf_n;
  logic             we;
  logic [N*ACC_W-1:0] row_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      k            <= '0;
      row          <= '0;
      overflow_err <= 1'b0;
    end else begin
      state        <= state_n;
      k            <= k_n;
      row          <= row_n;
      overflow_err <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    row_n   = row;
    ovf_n   = overflow_err;
    we      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (output_write) begin
          we = 1'b1;
          if (BEATS == 1) begin
            state_n = READOUT;
            row_n   = '0;
          end else begin
            state_n = CAPTURE;
            k_n     = KW'(1);
          end
        end
      end
      CAPTURE: begin
        if (output_write) begin
          we = 1'b1;
          if (k == K_LAST) begin
            state_n = READOUT;
            k_n     = '0;
            row_n   = '0;
          end else begin
            k_n = k + KW'(1);
          end
        end
      end
      READOUT: begin
        // Storage is frozen here; a drain beat can only be flagged.
        if (output_write) ovf_n = 1'b1;
        if (rd_ready) begin
          if (row == R_LAST) begin
            row_n   = '0;
            state_n = EMPTY;
          end else begin
            row_n = row + RW'(1);
          end
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  result_store #(
    .N     (N),
    .ACC_W (ACC_W),
    .KW    (KW),
    .RW    (RW)
  ) u_store (
    .clk        (clk),
    .we         (we),
    .k          (k),
    .drain_data (drain_data),
    .row        (row),
    .row_data   (row_data)
  );

  assign rd_valid  = (state == READOUT);
  assign rd_data   = rd_valid ? row_data : '0;
  assign rd_row    = row;
  assign rd_last   = rd_valid && (row == R_LAST);
  assign buf_empty = (state == EMPTY);

endmodule

// File: tb/tb_result_drain_buffer.sv
// Directed bench for result_drain_buffer: drains, deskew, readout
// handshake, backpressure, overflow and async reset.
module tb_result_drain_buffer;

  localparam int N = 8;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           output_write = 1'b0;
  logic [N*W-1:0] drain_data = '0;
  logic           rd_valid;
  logic           rd_ready = 1'b0;
  logic [N*W-1:0] rd_data;
  logic [2:0]     rd_row;
  logic           rd_last;
  logic           buf_empty;
  logic           overflow_err;

  int total = 0;
  int bad   = 0;

  result_drain_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .output_write (output_write),
    .drain_data   (drain_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_row       (rd_row),
    .rd_last      (rd_last),
    .buf_empty    (buf_empty),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ready;
    logic       valid;
    logic [2:0] row;
    logic       last;
  } bp_vec_t;

  bp_vec_t bp_tab [16];

  task automatic chk(input string name, input logic [N*W-1:0] act,
                     input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] beat(input int base, input int k);
    logic [N*W-1:0] v;
    for (int j = 0; j < N; j++) begin
      if (k >= j && k <= j + N - 1)
        v[j*W +: W] = W'(base + 100 * (k - j) + j);
      else
        v[j*W +: W] = W'(32'hDEAD);
    end
    return v;
  endfunction

  function automatic logic [N*W-1:0] row_exp(input int base, input int r);
    logic [N*W-1:0] v;
    for (int j = 0; j < N; j++) v[j*W +: W] = W'(base + 100 * r + j);
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, rd_valid, 0);
    chk({tag, "_data"}, rd_data, 0);
    chk({tag, "_row"}, rd_row, 0);
    chk({tag, "_last"}, rd_last, 0);
    chk({tag, "_empty"}, buf_empty, 1);
    chk({tag, "_ovf"}, overflow_err, 0);
  endtask

  // Starts and ends on a negedge; nb beats, optional 3-cycle gaps.
  task automatic drain(input int base, input int nb, input bit gap,
                       output int lat);
    lat = 0;
    for (int b = 0; b < nb; b++) begin
      chk("drain_valid_low", rd_valid, 0);
      output_write = 1'b1;
      drain_data   = beat(base, b);
      lat++;
      @(negedge clk);
      if (gap && (b == 2 || b == 9)) begin
        for (int g = 0; g < 3; g++) begin
          output_write = 1'b0;
          drain_data   = {N{32'hDEAD}};
          lat++;
          @(negedge clk);
        end
      end
    end
    output_write = 1'b0;
    drain_data   = '0;
  endtask

  task automatic readout(input int base, input int first, input bit ovf);
    for (int r = first; r < N; r++) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_row", rd_row, r);
      chk("rd_data", rd_data, row_exp(base, r));
      chk("rd_last", rd_last, (r == N - 1));
      chk("rd_ovf", overflow_err, ovf);
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk("post_empty", buf_empty, 1);
    chk("post_valid", rd_valid, 0);
    chk("post_data", rd_data, 0);
  endtask

  initial begin
    int lat;
    int hs;
    logic [3:0] pat;

    pat = 4'b1001;
    hs  = 0;
    for (int i = 0; i < 16; i++) begin
      bp_tab[i].ready = pat[3 - (i % 4)];
      bp_tab[i].valid = 1'b1;
      bp_tab[i].row   = 3'(hs);
      bp_tab[i].last  = (hs == N - 1);
      if (bp_tab[i].ready) hs++;
    end

    #2 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    drain(0, 15, 1'b0, lat);
    chk("contig_latency", lat, 15);
    readout(0, 0, 1'b0);

    drain(1000, 15, 1'b1, lat);
    chk("gapped_latency", lat, 21);
    readout(1000, 0, 1'b0);

    drain(2000, 15, 1'b0, lat);
    for (int i = 0; i < 16; i++) begin
      chk("bp_valid", rd_valid, bp_tab[i].valid);
      chk("bp_row", rd_row, bp_tab[i].row);
      chk("bp_last", rd_last, bp_tab[i].last);
      chk("bp_data", rd_data, row_exp(2000, bp_tab[i].row));
      rd_ready = bp_tab[i].ready;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk("bp_empty", buf_empty, 1);

    drain(3000, 15, 1'b0, lat);
    for (int r = 0; r < 3; r++) begin
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk("ovf_before", overflow_err, 0);
    output_write = 1'b1;
    drain_data   = {N{32'h0BAD_0BAD}};
    @(negedge clk);
    output_write = 1'b0;
    drain_data   = '0;
    chk("ovf_set", overflow_err, 1);
    readout(3000, 3, 1'b1);
    drain(4000, 15, 1'b0, lat);
    readout(4000, 0, 1'b1);

    drain(7000, 8, 1'b0, lat);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midcap_reset");
    @(negedge clk);
    rst = 1'b0;
    drain(5000, 15, 1'b0, lat);
    readout(5000, 0, 1'b0);

    drain(6000, 15, 1'b0, lat);
    for (int r = 0; r < 2; r++) begin
      rd_ready = 1'b1;
      @(negedge clk);
    end
    chk("midrd_row", rd_row, 2);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrd_reset");
    @(negedge clk);
    rst      = 1'b0;
    rd_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
